sw_host_sequencer: RTL and testbench

Automated stand-in for the human operator at the CPU's switch/LED port. It buffers a list of 8-bit operand words. It presents each word on the 9-bit `inport` bus using the bit-8 handshake protocol the picoMIPS program polls: data on bits 7:0, flag on bit 8. It captures the CPU's `outport` value after each handshake completes. It runs on the same clock as the CPU, so all hold times are in CPU cycles, and it drives the CPU's `inport` in place of the board switches during regression and demo runs.

---
 rtl/sw_host_sequencer.sv | 172 +++++++++++++++++
 tb/tb_sw_host_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_host_sequencer.sv
// ============================================================================
// Module   : sw_host_sequencer
// Purpose  : Feeds buffered operand words to the CPU inport with the bit-8
//            handshake and captures the CPU outport after each word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sw_host_sequencer #(
  parameter int DEPTH = 8,
  parameter int SETUP = 4,
  parameter int HOLD  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     start,
  output logic                     busy,
  output logic [8:0]               inport,
  input  logic [7:0]               outport,
  output logic                     res_valid,
  output logic [7:0]               res_data
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int TMAX = (SETUP > HOLD) ? SETUP : HOLD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] SETUP_T = TW'(SETUP - 1);
  localparam logic [TW-1:0] HOLD_T  = TW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    data_q, data_d;
  logic [8:0]    inport_q, inport_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic [7:0]    mem_q [DEPTH];

  logic          push;
  logic          pop;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    data_d      = data_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    pop         = 1'b0;
    push        = wr_en && !full_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (count_q != '0)) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          tmr_d   = SETUP_T;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_q == '0) begin
          tmr_d   = HOLD_T;
          state_d = ST_HIGH;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ST_HIGH: begin
        if (tmr_q == '0) begin
          tmr_d   = HOLD_T;
          state_d = ST_LOW;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ST_LOW: begin
        if (tmr_q == '0) begin
          res_valid_d = 1'b1;
          res_data_d  = outport;
          // Only words already counted before this edge may chain the session.
          if (count_q != '0) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            tmr_d   = SETUP_T;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    inport_d = {(state_d == ST_HIGH), data_d};
    busy_d   = (state_d != ST_IDLE);

    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      data_q      <= '0;
      inport_q    <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      data_q      <= data_d;
      inport_q    <= inport_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full      = full_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign inport    = inport_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_host_sequencer.sv
// ============================================================================
// Module   : tb_sw_host_sequencer
// Purpose  : Self-checking bench for sw_host_sequencer against a queue-based
//            reference model of the word/handshake timeline.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sw_host_sequencer;

  localparam int DEPTH  = 8;
  localparam int SETUP  = 4;
  localparam int HOLD   = 16;
  localparam int PERIOD = SETUP + 2 * HOLD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic [7:0] outport = '0;
  logic       full;
  logic [3:0] count;
  logic       busy;
  logic [8:0] inport;
  logic       res_valid;
  logic [7:0] res_data;

  always #5 clk = ~clk;

  sw_host_sequencer #(.DEPTH(DEPTH), .SETUP(SETUP), .HOLD(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .count     (count),
    .start     (start),
    .busy      (busy),
    .inport    (inport),
    .outport   (outport),
    .res_valid (res_valid),
    .res_data  (res_data)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: a word queue plus the position within the current word.
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  bit         m_rv = 1'b0;
  int         m_off = 0;
  logic [7:0] m_w = '0;
  logic [7:0] m_res = '0;
  int         strobes[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_edge();
    int  n;
    bit  was_full;
    m_rv = 1'b0;
    if (reset) begin
      q.delete();
      m_active = 1'b0;
      m_off    = 0;
      m_w      = '0;
      m_res    = '0;
    end else begin
      n        = q.size();
      was_full = (n == DEPTH);
      if (m_active && m_off == PERIOD) begin
        m_rv  = 1'b1;
        m_res = outport;
        if (n > 0) begin
          m_w   = q.pop_front();
          m_off = 1;
        end else begin
          m_active = 1'b0;
        end
      end else if (m_active) begin
        m_off++;
      end else if (start && n > 0) begin
        m_w      = q.pop_front();
        m_active = 1'b1;
        m_off    = 1;
      end
      if (wr_en && !was_full) q.push_back(wr_data);
    end
  endtask

  task automatic step();
    logic flag;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    flag = m_active && (m_off > SETUP) && (m_off <= SETUP + HOLD);
    check("inport",    inport,    {flag, m_w});
    check("busy",      busy,      m_active);
    check("res_valid", res_valid, m_rv);
    check("res_data",  res_data,  m_res);
    check("count",     count,     q.size());
    check("full",      full,      q.size() == DEPTH);
    if (res_valid && m_rv) strobes.push_back(cyc);
  endtask

  task automatic drive(input bit we, input logic [7:0] wd, input bit st, input bit rs);
    wr_en   = we;
    wr_data = wd;
    start   = st;
    reset   = rs;
    outport = 8'($urandom);
    step();
    wr_en = 1'b0;
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic run_until_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      k++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_off(input int target);
    int k = 0;
    while (!(m_active && m_off == target) && k < 200) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      k++;
    end
    check("wait_phase", m_off, target);
  endtask

  initial begin
    int k;
    int rise;
    int fall;

    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_inport", inport, 9'h000);
    check("rst_count",  count,  4'd0);

    // Start with nothing queued must be ignored.
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);
    check("empty_busy",   busy,   1'b0);
    check("empty_inport", inport, 9'h000);

    // Single word: handshake edges and result latency relative to start.
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("single_setup", inport, 9'h05A);
    k = 0; rise = -1; fall = -1;
    while (!res_valid && k < 100) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      k++;
      if (inport[8] && rise < 0) rise = k;
      if (!inport[8] && rise >= 0 && fall < 0) fall = k;
    end
    check("single_latency", k, PERIOD);
    check("flag_rise", rise, SETUP);
    check("flag_fall", fall, SETUP + HOLD);
    check("single_busy_end", busy, 1'b0);

    // Three words back to back.
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    strobes.delete();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    run_until_idle(200);
    check("three_strobes", strobes.size(), 3);
    if (strobes.size() == 3) begin
      check("three_gap1", strobes[1] - strobes[0], PERIOD);
      check("three_gap2", strobes[2] - strobes[1], PERIOD);
    end

    // Overfill, then two full sessions across pointer wrap.
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    check("fill_full",  full,  1'b1);
    check("fill_count", count, 4'd8);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    run_until_idle(400);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    check("refill_full", full, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    run_until_idle(400);

    // Push colliding with a chained pop.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    wait_off(PERIOD);
    drive(1'b1, 8'hCC, 1'b0, 1'b0);
    check("collide_count", count, 4'd3);
    run_until_idle(400);

    // Push on the last LOW cycle with an empty FIFO does not extend the session.
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    wait_off(PERIOD);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    check("lastlow_busy",  busy,  1'b0);
    check("lastlow_count", count, 4'd1);

    // Start during HIGH is ignored (model checks timing every cycle).
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    wait_off(SETUP + 3);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    run_until_idle(200);

    // Reset in the middle of HIGH.
    drive(1'b1, 8'h31, 1'b0, 1'b0);
    drive(1'b1, 8'h32, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(19);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_mid_inport", inport,    9'h000);
    check("rst_mid_busy",   busy,      1'b0);
    check("rst_mid_count",  count,     4'd0);
    check("rst_mid_rv",     res_valid, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    strobes.delete();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    run_until_idle(200);
    check("after_rst_strobes", strobes.size(), 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 999) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
